mips_inst_encoder: RTL and testbench
====================================

MIPS_INST_ENCODER -- requirements
Module: mips_inst_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with all other ports as listed below.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  a decoded-op descriptor is present.
REQ-005 Port: in_ready  output  1  the descriptor is accepted this cycle.
REQ-006 Port: in_pc  input  32  PC of the instruction being encoded.
REQ-007 Port: in_alu_ctl  input  AluCtl  ALU control enum from mips_core_pkg.
REQ-008 Port: in_is_branch, in_is_jump, in_is_jump_reg, in_is_mem_access, in_uses_immediate  input  1 each  descriptor flags.
REQ-009 Port: in_mem_action  input  MemAccessType  READ or WRITE.
REQ-010 Port: in_rs_addr, in_rt_addr, in_rw_addr  input  MipsReg  register fields.
REQ-011 Port: in_immediate  input  32  immediate; in_branch_target  input  32  branch or jump target.
REQ-012 Port: flush  input  1  synchronous discard of the output register.
REQ-013 Port: out_valid  output  1  out_inst is valid; out_ready  input  1  downstream accepts the word.
REQ-014 Port: out_inst  output  32  encoded MIPS word; out_err  output  1  unencodable descriptor, in which case out_inst SHALL be 32'h0.

Function
REQ-015 The block SHALL have a one-stage registered pipeline, with in_ready = !out_valid || out_ready.
- Handshake: in_valid && in_ready loads the output register on the next edge.
- Latency: exactly 1 cycle.
REQ-016 out_valid, out_inst and out_err SHALL hold stable while out_valid && !out_ready.
REQ-017 out_valid SHALL clear on a transfer without a new load; a simultaneous transfer and load SHALL keep out_valid=1 with the new word.
REQ-018 flush SHALL clear out_valid next cycle and SHALL override a simultaneous load; in_ready SHALL NOT depend on flush.
REQ-019 R-type encoding (uses_immediate=0, no branch, no mem): opcode 0; rs, rt, rd=rw; shamt 0; funct per alu_ctl:
- ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27
- SLLV 04, SRLV 06, SRAV 07, SLT 2a, SLTU 2b.
REQ-020 Shift encoding (SLL/SRL/SRA): opcode 0; rs field 0; rt field=in_rs_addr; rd=rw; shamt=imm[4:0]; funct 00/02/03.
REQ-021 I-type encoding (uses_immediate=1): opcode per alu_ctl ADD 08, ADDU 09, AND 0c, OR 0d, XOR 0e, SLT 0a, SLTU 0b; rt field=rw; imm16=imm[15:0].
REQ-022 An OR with rs=zero, imm[15:0]=0 and imm!=0 SHALL encode as lui (0f) with imm16=imm[31:16].
REQ-023 A memory access with alu ADD SHALL encode as lw (23, rt=rw) for READ and as sw (2b, rt=rt_addr) for WRITE.
REQ-024 Conditional branch encoding:
- opcodes: BEQ 04, BNE 05, BLEZ 06, BGTZ 07; BGEZ 01 with rt=1; BLTZ 01 with rt=0.
- offset = (target - pc - 4) >>> 2, with imm16 = offset[15:0].
- out_err SHALL be set if target[1:0]!=0 or the offset does not fit in signed 16 bits.
REQ-025 Jump encoding:
- jr: funct 08.
- jalr: funct 09 with rd=31.
- j: opcode 02; jal: opcode 03 (alu OR, rw=ra, not jump_reg).
- j and jal: field = target[27:2]; out_err SHALL be set if target[31:28] != (pc+4)[31:28].
REQ-026 MTCO_PASS/FAIL/DONE SHALL encode as opcode 10, rs 00100, rt=rt_addr, rd 17/18/19.
REQ-027 Any other combination SHALL assert out_err with out_inst=0.
REQ-028 The encoder SHALL be a pure function of the accepted descriptor and SHALL be registered only at the output.

Reset
REQ-029 Asserting rst_n low SHALL immediately clear out_valid, out_err and out_inst, including mid-stall; the stalled word SHALL be lost.
REQ-030 in_ready SHALL read 1 during reset and the first cycle after reset.

Configuration
REQ-031 When ENCODER_STATS_EN is defined, the block SHALL have two additional outputs:
- stat_encoded: 16-bit, counts transfers with out_err=0.
- stat_errors: 16-bit, counts transfers with out_err=1.
- Both SHALL saturate at FFFF, reset to 0, and count only on out_valid && out_ready.
REQ-032 When ENCODER_STATS_EN is undefined, the counters and ports SHALL be absent and the block behaviour SHALL be otherwise identical.

Verification
REQ-033 Test: ADDU with rs=4, rt=5, rw=2, out_ready=1 -> out_inst 00851021 one cycle later, out_err=0.
REQ-034 Test: BNE at pc=00400010 with target 00400000 -> out_inst 1485FFFB; with target 00480000 -> out_err=1, out_inst=0.
REQ-035 Test: OR with rs=0 and imm=12340000 -> 3C011234 (rw=1); jal at pc=00400000 with target 00400100 -> 0C100040.
REQ-036 Test: hold out_ready=0 for 3 cycles with in_valid=1 -> output stable and in_ready=0; release -> one transfer, then the next word; flush while stalled -> out_valid=0 next cycle.
REQ-037 Test: assert rst_n low mid-stall -> out_valid=0 immediately; with ENCODER_STATS_EN, 65536 good transfers -> stat_encoded=FFFF.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: ALU control, memory access direction and register index.
package mips_core_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV,
    ALU_BEQ, ALU_BNE, ALU_BLEZ, ALU_BGTZ, ALU_BGEZ, ALU_BLTZ,
    ALU_MTCO_PASS, ALU_MTCO_FAIL, ALU_MTCO_DONE, ALU_NOP
  } AluCtl;

  typedef enum logic {MEM_READ, MEM_WRITE} MemAccessType;

  typedef logic [4:0] MipsReg;

endpackage

// File: rtl/mips_inst_encoder_if.sv
// Descriptor-in / instruction-word-out bus of mips_inst_encoder.
interface mips_inst_encoder_if;
  import mips_core_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_pc;
  AluCtl        in_alu_ctl;
  logic         in_is_branch;
  logic         in_is_jump;
  logic         in_is_jump_reg;
  logic         in_is_mem_access;
  logic         in_uses_immediate;
  MemAccessType in_mem_action;
  MipsReg       in_rs_addr;
  MipsReg       in_rt_addr;
  MipsReg       in_rw_addr;
  logic [31:0]  in_immediate;
  logic [31:0]  in_branch_target;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_inst;
  logic         out_err;

  modport master (
    output in_valid, in_pc, in_alu_ctl, in_is_branch, in_is_jump, in_is_jump_reg,
           in_is_mem_access, in_uses_immediate, in_mem_action, in_rs_addr,
           in_rt_addr, in_rw_addr, in_immediate, in_branch_target, flush, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_pc, in_alu_ctl, in_is_branch, in_is_jump, in_is_jump_reg,
           in_is_mem_access, in_uses_immediate, in_mem_action, in_rs_addr,
           in_rt_addr, in_rw_addr, in_immediate, in_branch_target, flush, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );

endinterface

// File: rtl/mips_inst_encoder.sv
// Encodes a decoded-op descriptor into a 32-bit MIPS word through one output register.
// Optional ENCODER_STATS_EN adds saturating transfer counters stat_encoded / stat_errors.
module mips_inst_encoder
  import mips_core_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mips_inst_encoder_if.slave  bus
`ifdef ENCODER_STATS_EN
  ,
  output logic [15:0]         stat_encoded,
  output logic [15:0]         stat_errors
`endif
);

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  AluCtl       alu;
  MipsReg      rs, rt, rw;
  logic [31:0] imm, target;
  logic        jmp;
  logic [31:0] pc_plus4, br_diff, br_off;
  logic        br_fits;
  logic [31:0] enc_word;
  logic        enc_bad;

  logic        valid_q;
  logic [31:0] inst_q;
  logic        err_q;

  assign alu      = bus.in_alu_ctl;
  assign rs       = bus.in_rs_addr;
  assign rt       = bus.in_rt_addr;
  assign rw       = bus.in_rw_addr;
  assign imm      = bus.in_immediate;
  assign target   = bus.in_branch_target;
  assign jmp      = bus.in_is_jump | bus.in_is_jump_reg;

  // Word offset from the delay slot; must survive truncation to a signed 16-bit field.
  assign pc_plus4 = bus.in_pc + 32'd4;
  assign br_diff  = target - pc_plus4;
  assign br_off   = $signed(br_diff) >>> 2;
  assign br_fits  = (br_off[31:15] == '0) || (br_off[31:15] == '1);

  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    if ((bus.in_is_branch && jmp) || (bus.in_is_branch && bus.in_is_mem_access) ||
        (jmp && bus.in_is_mem_access)) begin
      enc_bad = 1'b1;
    end else if (bus.in_is_mem_access) begin
      if (alu != ALU_ADD)                        enc_bad  = 1'b1;
      else if (bus.in_mem_action == MEM_READ)    enc_word = i_word(6'h23, rs, rw, imm[15:0]);
      else                                       enc_word = i_word(6'h2b, rs, rt, imm[15:0]);
    end else if (bus.in_is_branch) begin
      case (alu)
        ALU_BEQ:  enc_word = i_word(6'h04, rs, rt,   br_off[15:0]);
        ALU_BNE:  enc_word = i_word(6'h05, rs, rt,   br_off[15:0]);
        ALU_BLEZ: enc_word = i_word(6'h06, rs, 5'd0, br_off[15:0]);
        ALU_BGTZ: enc_word = i_word(6'h07, rs, 5'd0, br_off[15:0]);
        ALU_BGEZ: enc_word = i_word(6'h01, rs, 5'd1, br_off[15:0]);
        ALU_BLTZ: enc_word = i_word(6'h01, rs, 5'd0, br_off[15:0]);
        default:  enc_bad  = 1'b1;
      endcase
      if (target[1:0] != 2'b00 || !br_fits) enc_bad = 1'b1;
    end else if (bus.in_is_jump_reg) begin
      if (rw == 5'd31)      enc_word = r_word(rs, 5'd0, 5'd31, 5'd0, 6'h09);
      else if (rw == 5'd0)  enc_word = r_word(rs, 5'd0, 5'd0,  5'd0, 6'h08);
      else                  enc_bad  = 1'b1;
    end else if (bus.in_is_jump) begin
      enc_word = {(alu == ALU_OR && rw == 5'd31) ? 6'h03 : 6'h02, target[27:2]};
      if (target[31:28] != pc_plus4[31:28]) enc_bad = 1'b1;
    end else begin
      case (alu)
        ALU_MTCO_PASS: enc_word = {6'h10, 5'd4, rt, 5'd17, 11'd0};
        ALU_MTCO_FAIL: enc_word = {6'h10, 5'd4, rt, 5'd18, 11'd0};
        ALU_MTCO_DONE: enc_word = {6'h10, 5'd4, rt, 5'd19, 11'd0};
        // Constant shifts carry the source register in the rt slot.
        ALU_SLL:       enc_word = r_word(5'd0, rs, rw, imm[4:0], 6'h00);
        ALU_SRL:       enc_word = r_word(5'd0, rs, rw, imm[4:0], 6'h02);
        ALU_SRA:       enc_word = r_word(5'd0, rs, rw, imm[4:0], 6'h03);
        default: begin
          if (bus.in_uses_immediate) begin
            case (alu)
              ALU_ADD:  enc_word = i_word(6'h08, rs, rw, imm[15:0]);
              ALU_ADDU: enc_word = i_word(6'h09, rs, rw, imm[15:0]);
              ALU_AND:  enc_word = i_word(6'h0c, rs, rw, imm[15:0]);
              ALU_XOR:  enc_word = i_word(6'h0e, rs, rw, imm[15:0]);
              ALU_SLT:  enc_word = i_word(6'h0a, rs, rw, imm[15:0]);
              ALU_SLTU: enc_word = i_word(6'h0b, rs, rw, imm[15:0]);
              ALU_OR: begin
                if (rs == 5'd0 && imm[15:0] == 16'h0000 && imm != '0)
                  enc_word = i_word(6'h0f, 5'd0, rw, imm[31:16]);
                else
                  enc_word = i_word(6'h0d, rs, rw, imm[15:0]);
              end
              default:  enc_bad = 1'b1;
            endcase
          end else begin
            case (alu)
              ALU_ADD:  enc_word = r_word(rs, rt, rw, 5'd0, 6'h20);
              ALU_ADDU: enc_word = r_word(rs, rt, rw, 5'd0, 6'h21);
              ALU_SUB:  enc_word = r_word(rs, rt, rw, 5'd0, 6'h22);
              ALU_SUBU: enc_word = r_word(rs, rt, rw, 5'd0, 6'h23);
              ALU_AND:  enc_word = r_word(rs, rt, rw, 5'd0, 6'h24);
              ALU_OR:   enc_word = r_word(rs, rt, rw, 5'd0, 6'h25);
              ALU_XOR:  enc_word = r_word(rs, rt, rw, 5'd0, 6'h26);
              ALU_NOR:  enc_word = r_word(rs, rt, rw, 5'd0, 6'h27);
              ALU_SLLV: enc_word = r_word(rs, rt, rw, 5'd0, 6'h04);
              ALU_SRLV: enc_word = r_word(rs, rt, rw, 5'd0, 6'h06);
              ALU_SRAV: enc_word = r_word(rs, rt, rw, 5'd0, 6'h07);
              ALU_SLT:  enc_word = r_word(rs, rt, rw, 5'd0, 6'h2a);
              ALU_SLTU: enc_word = r_word(rs, rt, rw, 5'd0, 6'h2b);
              default:  enc_bad = 1'b1;
            endcase
          end
        end
      endcase
    end
    if (enc_bad) enc_word = '0;
  end

  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_inst  = inst_q;
  assign bus.out_err   = err_q;

  // Flush wins over a same-cycle load; a stalled word is simply held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (bus.in_valid && bus.in_ready) begin
      valid_q <= 1'b1;
      inst_q  <= enc_word;
      err_q   <= enc_bad;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef ENCODER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_encoded <= '0;
      stat_errors  <= '0;
    end else if (valid_q && bus.out_ready) begin
      if (err_q) begin
        if (stat_errors != '1) stat_errors <= stat_errors + 16'd1;
      end else begin
        if (stat_encoded != '1) stat_encoded <= stat_encoded + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Self-checking bench for mips_inst_encoder: directed vector table, handshake sequences, random traffic.
module tb_mips_inst_encoder;
  import mips_core_pkg::*;

  typedef struct {
    logic [31:0]  pc;
    AluCtl        alu;
    logic         br, j, jr, mem, uimm;
    MemAccessType act;
    logic [4:0]   rs, rt, rw;
    logic [31:0]  imm, tgt;
  } desc_t;

  typedef struct {
    string       name;
    desc_t       d;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  localparam logic [4:0] F_NONE = 5'b00000, F_BR = 5'b10000, F_J = 5'b01000,
                         F_JR = 5'b00100, F_MEM = 5'b00010, F_IMM = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_inst_encoder_if bus();
`ifdef ENCODER_STATS_EN
  logic [15:0] stat_encoded, stat_errors;
`endif

  mips_inst_encoder dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef ENCODER_STATS_EN
    ,
    .stat_encoded(stat_encoded),
    .stat_errors(stat_errors)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  desc_t       cur;
  logic        m_valid;
  logic [31:0] m_inst;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic desc_t mkd(input AluCtl alu, input logic [4:0] fl, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rw, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [31:0] tgt,
                                input MemAccessType act = MEM_READ);
    desc_t d;
    d.pc = pc; d.alu = alu; d.act = act;
    {d.br, d.j, d.jr, d.mem, d.uimm} = fl;
    d.rs = rs; d.rt = rt; d.rw = rw; d.imm = imm; d.tgt = tgt;
    return d;
  endfunction

  function automatic vec_t mkv(input string name, input desc_t d, input logic [31:0] inst,
                               input logic err);
    vec_t v;
    v.name = name; v.d = d; v.inst = inst; v.err = err;
    return v;
  endfunction

  // Reference encoder: field values computed from the instruction-format rules, then packed arithmetically.
  function automatic void ref_enc(input desc_t d, output logic [31:0] w, output logic e);
    int unsigned op, rs, rt, rd, sh, fn, lo16;
    bit          itype, jtype, jmp;
    longint      off;
    logic [31:0] pc4;
    int          kinds;
    op = 0; rs = 0; rt = 0; rd = 0; sh = 0; fn = 0; lo16 = 0;
    itype = 0; jtype = 0; e = 0;
    jmp   = d.j || d.jr;
    pc4   = d.pc + 32'd4;
    kinds = int'(d.br) + int'(jmp) + int'(d.mem);
    if (kinds > 1) e = 1;
    else if (d.mem) begin
      itype = 1;
      if (d.alu != ALU_ADD) e = 1;
      else begin
        op = (d.act == MEM_READ) ? 'h23 : 'h2b;
        rs = d.rs; rt = (d.act == MEM_READ) ? d.rw : d.rt; lo16 = d.imm[15:0];
      end
    end else if (d.br) begin
      itype = 1; rs = d.rs;
      case (d.alu)
        ALU_BEQ:  begin op = 4; rt = d.rt; end
        ALU_BNE:  begin op = 5; rt = d.rt; end
        ALU_BLEZ: op = 6;
        ALU_BGTZ: op = 7;
        ALU_BGEZ: begin op = 1; rt = 1; end
        ALU_BLTZ: op = 1;
        default:  e = 1;
      endcase
      off = (longint'(d.tgt) - longint'(d.pc) - 4) / 4;
      if (d.tgt[1:0] != 0 || off < -32768 || off > 32767) e = 1;
      lo16 = int'(off) & 'hFFFF;
    end else if (d.jr) begin
      rs = d.rs;
      if (d.rw == 31) begin rd = 31; fn = 9; end
      else if (d.rw == 0) fn = 8;
      else e = 1;
    end else if (d.j) begin
      jtype = 1;
      op = (d.alu == ALU_OR && d.rw == 31) ? 3 : 2;
      if ((d.tgt >> 28) != (pc4 >> 28)) e = 1;
    end else if (d.alu inside {ALU_MTCO_PASS, ALU_MTCO_FAIL, ALU_MTCO_DONE}) begin
      op = 'h10; rs = 4; rt = d.rt;
      rd = (d.alu == ALU_MTCO_PASS) ? 17 : (d.alu == ALU_MTCO_FAIL) ? 18 : 19;
    end else if (d.alu inside {ALU_SLL, ALU_SRL, ALU_SRA}) begin
      rt = d.rs; rd = d.rw; sh = d.imm % 32;
      fn = (d.alu == ALU_SLL) ? 0 : (d.alu == ALU_SRL) ? 2 : 3;
    end else if (d.uimm) begin
      itype = 1; rs = d.rs; rt = d.rw; lo16 = d.imm % 65536;
      case (d.alu)
        ALU_ADD:  op = 'h08;  ALU_ADDU: op = 'h09;  ALU_AND: op = 'h0c;
        ALU_XOR:  op = 'h0e;  ALU_SLT:  op = 'h0a;  ALU_SLTU: op = 'h0b;
        ALU_OR: begin
          if (d.rs == 0 && d.imm % 65536 == 0 && d.imm != 0) begin
            op = 'h0f; rs = 0; lo16 = d.imm / 65536;
          end else op = 'h0d;
        end
        default: e = 1;
      endcase
    end else begin
      rs = d.rs; rt = d.rt; rd = d.rw;
      case (d.alu)
        ALU_ADD: fn = 'h20;  ALU_ADDU: fn = 'h21; ALU_SUB: fn = 'h22;  ALU_SUBU: fn = 'h23;
        ALU_AND: fn = 'h24;  ALU_OR:   fn = 'h25; ALU_XOR: fn = 'h26;  ALU_NOR:  fn = 'h27;
        ALU_SLLV: fn = 'h04; ALU_SRLV: fn = 'h06; ALU_SRAV: fn = 'h07;
        ALU_SLT: fn = 'h2a;  ALU_SLTU: fn = 'h2b;
        default: e = 1;
      endcase
    end
    if (jtype)      w = (op << 26) | ((d.tgt % 32'h1000_0000) / 4);
    else if (itype) w = (op << 26) | (rs << 21) | (rt << 16) | lo16;
    else            w = (op << 26) | (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
    if (e) w = '0;
  endfunction

  task automatic apply(input desc_t d);
    cur                   = d;
    bus.in_pc             = d.pc;
    bus.in_alu_ctl        = d.alu;
    bus.in_is_branch      = d.br;
    bus.in_is_jump        = d.j;
    bus.in_is_jump_reg    = d.jr;
    bus.in_is_mem_access  = d.mem;
    bus.in_uses_immediate = d.uimm;
    bus.in_mem_action     = d.act;
    bus.in_rs_addr        = d.rs;
    bus.in_rt_addr        = d.rt;
    bus.in_rw_addr        = d.rw;
    bus.in_immediate      = d.imm;
    bus.in_branch_target  = d.tgt;
  endtask

  // One clock: compare DUT to model, then advance the model with the inputs present at the edge.
  task automatic cycle(input string tag);
    logic [31:0] w;
    logic        e;
    #1;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, " out_inst"}, bus.out_inst, m_inst);
      chk({tag, " out_err"}, 32'(bus.out_err), 32'(m_err));
    end
    ref_enc(cur, w, e);
    @(posedge clk);
    if (bus.flush) m_valid = 1'b0;
    else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      m_valid = 1'b1; m_inst = w; m_err = e;
    end else if (bus.out_ready) m_valid = 1'b0;
    #1;
  endtask

  function automatic desc_t rand_desc();
    desc_t d;
    AluCtl br_ops[6] = '{ALU_BEQ, ALU_BNE, ALU_BLEZ, ALU_BGTZ, ALU_BGEZ, ALU_BLTZ};
    AluCtl sh_ops[3] = '{ALU_SLL, ALU_SRL, ALU_SRA};
    int    off;
    d = mkd(AluCtl'(5'($urandom_range(0, 25))), F_NONE, 5'($urandom), 5'($urandom),
            5'($urandom), 32'h0040_0000 + ($urandom_range(0, 65535) << 2), $urandom, $urandom,
            MemAccessType'($urandom_range(0, 1)));
    case ($urandom_range(0, 8))
      0: ;
      1: d.alu = sh_ops[$urandom_range(0, 2)];
      2: d.uimm = 1'b1;
      3: begin d.uimm = 1'b1; d.alu = ALU_OR; d.rs = 5'd0; d.imm = $urandom & 32'hFFFF_0000; end
      4: begin d.mem = 1'b1; if ($urandom_range(0, 3) != 0) d.alu = ALU_ADD; end
      5: begin
        d.br = 1'b1;
        if ($urandom_range(0, 7) != 0) d.alu = br_ops[$urandom_range(0, 5)];
        off = int'($urandom_range(0, 80000)) - 40000;
        d.tgt = d.pc + 32'd4 + 32'(off * 4) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      end
      6: begin
        d.j = 1'b1;
        d.alu = ($urandom_range(0, 1) == 1) ? ALU_OR : ALU_ADD;
        if ($urandom_range(0, 1) == 1) d.rw = 5'd31;
        if ($urandom_range(0, 3) != 0) d.tgt = {d.pc[31:28], 28'($urandom)};
      end
      7: begin
        d.jr = 1'b1;
        case ($urandom_range(0, 2)) 0: d.rw = 5'd0; 1: d.rw = 5'd31; default: ; endcase
      end
      default: {d.br, d.j, d.jr, d.mem, d.uimm} = 5'($urandom);
    endcase
    return d;
  endfunction

  vec_t tbl[$];

  initial begin
    tbl.push_back(mkv("addu",      mkd(ALU_ADDU, F_NONE, 4, 5, 2, 32'h0040_0000, 0, 0), 32'h0085_1021, 0));
    tbl.push_back(mkv("bne_back",  mkd(ALU_BNE, F_BR, 4, 5, 0, 32'h0040_0010, 0, 32'h0040_0000), 32'h1485_FFFB, 0));
    tbl.push_back(mkv("bne_far",   mkd(ALU_BNE, F_BR, 4, 5, 0, 32'h0040_0010, 0, 32'h0048_0000), 32'h0, 1));
    tbl.push_back(mkv("lui",       mkd(ALU_OR, F_IMM, 0, 0, 1, 32'h0040_0000, 32'h1234_0000, 0), 32'h3C01_1234, 0));
    tbl.push_back(mkv("jal",       mkd(ALU_OR, F_J, 0, 0, 31, 32'h0040_0000, 0, 32'h0040_0100), 32'h0C10_0040, 0));
    tbl.push_back(mkv("sll",       mkd(ALU_SLL, F_NONE, 3, 0, 7, 32'h0040_0000, 5, 0), 32'h0003_3940, 0));
    tbl.push_back(mkv("lw",        mkd(ALU_ADD, F_MEM, 29, 0, 8, 32'h0040_0000, 32'h10, 0), 32'h8FA8_0010, 0));
    tbl.push_back(mkv("sw",        mkd(ALU_ADD, F_MEM, 29, 9, 0, 32'h0040_0000, 32'hFFFC, 0, MEM_WRITE), 32'hAFA9_FFFC, 0));
    tbl.push_back(mkv("br_misal",  mkd(ALU_BEQ, F_BR, 1, 2, 0, 32'h0040_0000, 0, 32'h0040_0002), 32'h0, 1));
    tbl.push_back(mkv("br_max",    mkd(ALU_BEQ, F_BR, 1, 2, 0, 32'h0040_0000, 0, 32'h0042_0000), 32'h1022_7FFF, 0));
    tbl.push_back(mkv("br_max+1",  mkd(ALU_BEQ, F_BR, 1, 2, 0, 32'h0040_0000, 0, 32'h0042_0004), 32'h0, 1));
    tbl.push_back(mkv("br_min",    mkd(ALU_BEQ, F_BR, 0, 0, 0, 32'h0040_0000, 0, 32'h003E_0004), 32'h1000_8000, 0));
    tbl.push_back(mkv("jr",        mkd(ALU_ADD, F_JR, 31, 0, 0, 32'h0040_0000, 0, 0), 32'h03E0_0008, 0));
    tbl.push_back(mkv("jalr",      mkd(ALU_ADD, F_JR, 5, 0, 31, 32'h0040_0000, 0, 0), 32'h00A0_F809, 0));
    tbl.push_back(mkv("j_region",  mkd(ALU_ADD, F_J, 0, 0, 0, 32'h0FFF_FFFC, 0, 32'h1000_0000), 32'h0800_0000, 0));
    tbl.push_back(mkv("j_far",     mkd(ALU_ADD, F_J, 0, 0, 0, 32'h0040_0000, 0, 32'h1000_0000), 32'h0, 1));
    tbl.push_back(mkv("mtco_pass", mkd(ALU_MTCO_PASS, F_NONE, 0, 3, 0, 32'h0040_0000, 0, 0), 32'h4083_8800, 0));
    tbl.push_back(mkv("nor_imm",   mkd(ALU_NOR, F_IMM, 1, 2, 3, 32'h0040_0000, 5, 0), 32'h0, 1));
    tbl.push_back(mkv("bgez",      mkd(ALU_BGEZ, F_BR, 6, 0, 0, 32'h0040_0000, 0, 32'h0040_0008), 32'h04C1_0001, 0));
    tbl.push_back(mkv("addiu",     mkd(ALU_ADDU, F_IMM, 2, 0, 3, 32'h0040_0000, 32'hFFFF_8000, 0), 32'h2443_8000, 0));
    tbl.push_back(mkv("ori_zero",  mkd(ALU_OR, F_IMM, 0, 0, 1, 32'h0040_0000, 0, 0), 32'h3401_0000, 0));
    tbl.push_back(mkv("br_jmp",    mkd(ALU_BEQ, F_BR | F_J, 1, 2, 0, 32'h0040_0000, 0, 32'h0040_0008), 32'h0, 1));

    apply(tbl[0].d);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    m_valid = 1'b0; m_inst = '0; m_err = 1'b0;
    #12;
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset out_inst", bus.out_inst, 0);
    chk("reset out_err", 32'(bus.out_err), 0);
    chk("reset in_ready", 32'(bus.in_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", 32'(bus.in_ready), 1);

    // Directed vectors, streamed back to back with out_ready held high.
    bus.out_ready = 1'b1;
    foreach (tbl[i]) begin
      apply(tbl[i].d);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tbl[i].name, " valid"}, 32'(bus.out_valid), 1);
      chk({tbl[i].name, " inst"}, bus.out_inst, tbl[i].inst);
      chk({tbl[i].name, " err"}, 32'(bus.out_err), 32'(tbl[i].err));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain out_valid", 32'(bus.out_valid), 0);

    // Stall three cycles with a new descriptor waiting, release, then flush while stalled.
    apply(tbl[0].d); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    cycle("stall_load");
    apply(tbl[5].d);
    for (int unsigned k = 0; k < 3; k++) cycle("stall_hold");
    bus.out_ready = 1'b1;
    cycle("release");
    bus.in_valid = 1'b0;
    cycle("next_word");
    apply(tbl[6].d); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    cycle("stall2");
    bus.flush = 1'b1;
    cycle("flush");
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    cycle("after_flush");

    // Flush beats a simultaneous load.
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.flush = 1'b1;
    cycle("flush_vs_load");
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    cycle("flush_vs_load_after");

    // Asynchronous reset in the middle of a stall.
    apply(tbl[1].d); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    cycle("pre_reset_load");
    cycle("pre_reset_stall");
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset out_valid", 32'(bus.out_valid), 0);
    chk("async_reset out_inst", bus.out_inst, 0);
    chk("async_reset in_ready", 32'(bus.in_ready), 1);
    m_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("post_reset");

    // Random traffic against the reference model.
    for (int unsigned k = 0; k < 800; k++) begin
      apply(rand_desc());
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cycle("rand_drain");

`ifdef ENCODER_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("stat_encoded reset", 32'(stat_encoded), 0);
    chk("stat_errors reset", 32'(stat_errors), 0);
    m_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    apply(tbl[2].d); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    apply(tbl[0].d);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stat_errors one", 32'(stat_errors), 1);
    chk("stat_encoded one", 32'(stat_encoded), 1);
    for (int unsigned k = 0; k < 65536; k++) @(posedge clk);
    #1;
    chk("stat_encoded saturate", 32'(stat_encoded), 32'hFFFF);
    chk("stat_errors hold", 32'(stat_errors), 1);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
